// File: rtl/vga_fill_engine.sv
// vga_fill_engine
//   Draws one pixel per clock into a VGA pixel-write interface. Three operations:
//     mode 0  rainbow : a margin-inset rectangle is redrawn frame after frame while
//                       the colour ramps FF0000 -> yellow -> green -> cyan -> blue ->
//                       magenta -> FF0000, one component step per frame.
//     mode 1  fill    : one frame of the inset rectangle in fill_color.
//     mode 2/3 clear  : one frame of the whole screen in 000000.
//
//   Control protocol: start is looked at only while busy=0 (IDLE). Once accepted,
//   busy stays high until the cycle after the one-cycle done pulse. abort drops
//   the engine back to IDLE on the next edge from any busy state, without done.
//   Every pixel is presented on VGA_X/VGA_Y/VGA_COLOR in the same cycle plot=1.
//
//   Ports
//     CLOCK_50, Resetn        clock, synchronous active-low reset
//     start, abort, mode      control inputs
//     fill_color              RGB888 colour for mode 1
//     busy, done              status (done is a single-cycle pulse)
//     VGA_X, VGA_Y, VGA_COLOR, plot   pixel write port
//     HEX5..HEX0              seven-segment outputs, active-low
//     state_dbg               current FSM state (0 IDLE, 1 DRAW, 2 DONE)
//
//   Build option: define VGA_FILL_HEX_EN to show the colour register on
//   HEX5..HEX0; otherwise the displays are held blank.
module vga_fill_engine #(
    parameter int         COLS         = 320,
    parameter int         ROWS         = 240,
    parameter int         nX           = 9,
    parameter int         nY           = 8,
    parameter int         MARGIN_SHIFT = 2,
    parameter logic [7:0] STEP         = 8'h11
) (
    input  logic          CLOCK_50,
    input  logic          Resetn,
    input  logic          start,
    input  logic          abort,
    input  logic [1:0]    mode,
    input  logic [23:0]   fill_color,
    output logic          busy,
    output logic          done,
    output logic [nX-1:0] VGA_X,
    output logic [nY-1:0] VGA_Y,
    output logic [23:0]   VGA_COLOR,
    output logic          plot,
    output logic [6:0]    HEX0,
    output logic [6:0]    HEX1,
    output logic [6:0]    HEX2,
    output logic [6:0]    HEX3,
    output logic [6:0]    HEX4,
    output logic [6:0]    HEX5,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, DRAW = 2'd1, DONE = 2'd2} state_t;

    localparam int MX = COLS >> MARGIN_SHIFT;
    localparam int MY = ROWS >> MARGIN_SHIFT;

    localparam logic [nX-1:0] WIN_X0  = nX'(MX);
    localparam logic [nX-1:0] WIN_X1  = nX'(COLS - MX);
    localparam logic [nY-1:0] WIN_Y0  = nY'(MY);
    localparam logic [nY-1:0] WIN_Y1  = nY'(ROWS - MY);
    localparam logic [nX-1:0] FULL_X1 = nX'(COLS - 1);
    localparam logic [nY-1:0] FULL_Y1 = nY'(ROWS - 1);

    state_t      state;
    logic [1:0]  mode_q;
    logic [2:0]  phase;
    logic [23:0] color;

    assign state_dbg = state;

    // Scan window of the running operation (mode bit 1 selects full screen).
    logic [nX-1:0] x0, x1;
    logic [nY-1:0] y0, y1;
    always_comb begin
        if (mode_q[1]) begin
            x0 = '0;     x1 = FULL_X1;
            y0 = '0;     y1 = FULL_Y1;
        end else begin
            x0 = WIN_X0; x1 = WIN_X1;
            y0 = WIN_Y0; y1 = WIN_Y1;
        end
    end

    // Load values for the edge that accepts start (uses the live mode input).
    logic [nX-1:0] start_x;
    logic [nY-1:0] start_y;
    logic [23:0]   load_color;
    always_comb begin
        start_x    = mode[1] ? '0 : WIN_X0;
        start_y    = mode[1] ? '0 : WIN_Y0;
        load_color = 24'h000000;
        if (mode == 2'd0)      load_color = 24'hFF0000;
        else if (mode == 2'd1) load_color = fill_color;
    end

    // Per-frame ramp step: pick one component, move it by STEP with saturation,
    // and flag when it has reached the end of its travel.
    logic [7:0]  sel, sel_new;
    logic        dir_up, ramp_limit;
    logic [23:0] ramp_color;
    always_comb begin
        sel    = color[15:8];
        dir_up = 1'b1;
        case (phase)
            3'd0:    begin sel = color[15:8];  dir_up = 1'b1; end
            3'd1:    begin sel = color[23:16]; dir_up = 1'b0; end
            3'd2:    begin sel = color[7:0];   dir_up = 1'b1; end
            3'd3:    begin sel = color[15:8];  dir_up = 1'b0; end
            3'd4:    begin sel = color[23:16]; dir_up = 1'b1; end
            3'd5:    begin sel = color[7:0];   dir_up = 1'b0; end
            default: begin sel = color[15:8];  dir_up = 1'b1; end
        endcase
        if (dir_up) sel_new = (sel > (8'hFF - STEP)) ? 8'hFF : sel + STEP;
        else        sel_new = (sel < STEP) ? 8'h00 : sel - STEP;
        ramp_limit = dir_up ? (sel_new == 8'hFF) : (sel_new == 8'h00);
        ramp_color = color;
        case (phase)
            3'd0, 3'd3: ramp_color[15:8]  = sel_new;
            3'd1, 3'd4: ramp_color[23:16] = sel_new;
            3'd2, 3'd5: ramp_color[7:0]   = sel_new;
            default:    ramp_color        = color;
        endcase
    end

    logic last_pix;
    assign last_pix = (VGA_X == x1) && (VGA_Y == y1);

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state     <= IDLE;
            mode_q    <= 2'd0;
            phase     <= 3'd0;
            color     <= 24'h000000;
            VGA_X     <= '0;
            VGA_Y     <= '0;
            VGA_COLOR <= 24'h000000;
            plot      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    plot <= 1'b0;
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start && !abort) begin
                        state     <= DRAW;
                        mode_q    <= mode;
                        phase     <= 3'd0;
                        color     <= load_color;
                        VGA_COLOR <= load_color;
                        VGA_X     <= start_x;
                        VGA_Y     <= start_y;
                        plot      <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                DRAW: begin
                    if (abort) begin
                        state <= IDLE;
                        plot  <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else if (last_pix) begin
                        VGA_X <= x0;
                        VGA_Y <= y0;
                        if (mode_q != 2'd0 || phase == 3'd6) begin
                            state <= DONE;
                            plot  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            color     <= ramp_color;
                            VGA_COLOR <= ramp_color;
                            if (ramp_limit) phase <= phase + 3'd1;
                        end
                    end else if (VGA_X == x1) begin
                        VGA_X <= x0;
                        VGA_Y <= VGA_Y + nY'(1);
                    end else begin
                        VGA_X <= VGA_X + nX'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    plot  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    plot  <= 1'b0;
                end
            endcase
        end
    end

`ifdef VGA_FILL_HEX_EN
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Displays follow the colour register one cycle later; reset shows zeros.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            HEX5 <= 7'b1000000; HEX4 <= 7'b1000000; HEX3 <= 7'b1000000;
            HEX2 <= 7'b1000000; HEX1 <= 7'b1000000; HEX0 <= 7'b1000000;
        end else begin
            HEX5 <= seg7(color[23:20]); HEX4 <= seg7(color[19:16]);
            HEX3 <= seg7(color[15:12]); HEX2 <= seg7(color[11:8]);
            HEX1 <= seg7(color[7:4]);   HEX0 <= seg7(color[3:0]);
        end
    end
`else
    assign HEX5 = 7'h7F;
    assign HEX4 = 7'h7F;
    assign HEX3 = 7'h7F;
    assign HEX2 = 7'h7F;
    assign HEX1 = 7'h7F;
    assign HEX0 = 7'h7F;
`endif

endmodule

// File: tb/tb_vga_fill_engine.sv
module tb_vga_fill_engine;
  localparam int COLS = 16;
  localparam int ROWS = 8;
  localparam int NX   = 5;
  localparam int NY   = 4;
  localparam int W    = NX + NY + 24;

`ifdef VGA_FILL_HEX_EN
  localparam logic [6:0] HEX_RST = 7'b1000000;
`else
  localparam logic [6:0] HEX_RST = 7'h7F;
`endif

  // ---------------- clock / reset ----------------
  logic          CLOCK_50 = 1'b0;
  logic          Resetn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [23:0]   fill_color = 24'h0;
  logic          busy, done, plot;
  logic [NX-1:0] VGA_X;
  logic [NY-1:0] VGA_Y;
  logic [23:0]   VGA_COLOR;
  logic [6:0]    HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [1:0]    state_dbg;

  always #10 CLOCK_50 = ~CLOCK_50;

  vga_fill_engine #(.COLS(COLS), .ROWS(ROWS), .nX(NX), .nY(NY),
                    .MARGIN_SHIFT(2), .STEP(8'h11)) dut (
    .CLOCK_50(CLOCK_50), .Resetn(Resetn), .start(start), .abort(abort),
    .mode(mode), .fill_color(fill_color), .busy(busy), .done(done),
    .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOR(VGA_COLOR), .plot(plot),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
    .state_dbg(state_dbg)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got busy=%0b want completion", busy);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic push_rect(input int x0, input int x1, input int y0, input int y1,
                           input logic [23:0] c);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        exp_q.push_back({NX'(x), NY'(y), c});
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [23:0] c);
    @(negedge CLOCK_50);
    mode = m;
    fill_color = c;
    start = 1'b1;
    @(posedge CLOCK_50);
    #1 start = 1'b0;
  endtask

  // Scoreboard: every plot cycle pops one expected pixel. Returns after the
  // stop_at-th pixel (if stop_at > 0) or once the engine is idle again.
  task automatic run_scoreboard(input int budget, input int stop_at,
                                output int n_plot, output int n_done,
                                output int n_gap, output bit timeout);
    logic [W-1:0] e;
    n_plot = 0; n_done = 0; n_gap = 0; timeout = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge CLOCK_50);
      if (plot) begin
        n_plot++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_pixel: got x=%0d y=%0d c=%06h, want no pixel", VGA_X, VGA_Y, VGA_COLOR);
        end else begin
          e = exp_q.pop_front();
          if ({VGA_X, VGA_Y, VGA_COLOR} !== e) begin
            n_err++;
            $display("FAIL pixel: got x=%0d y=%0d c=%06h, want x=%0d y=%0d c=%06h",
                     VGA_X, VGA_Y, VGA_COLOR, e[W-1 -: NX], e[23+NY -: NY], e[23:0]);
          end
        end
      end else if (busy && !done) begin
        n_gap++;
      end
      if (done) begin
        n_done++;
        n_cmp++;
        if (plot !== 1'b0) begin
          n_err++;
          $display("FAIL done_plot: got plot=%0b, want 0", plot);
        end
      end
      if (stop_at > 0 && n_plot == stop_at) begin timeout = 1'b0; break; end
      if (!busy && (n_done > 0 || n_plot > 0)) begin timeout = 1'b0; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    Resetn = 1'b0; start = 1'b1; mode = 2'd1; fill_color = 24'hFFFFFF;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    n_cmp++;
    if ({busy, done, plot, state_dbg} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got busy=%0b done=%0b plot=%0b state=%0d, want 0 0 0 0", busy, done, plot, state_dbg);
    end
    n_cmp++;
    if ({VGA_X, VGA_Y, VGA_COLOR} !== '0) begin
      n_err++;
      $display("FAIL reset_pixel: got x=%0d y=%0d c=%06h, want 0 0 000000", VGA_X, VGA_Y, VGA_COLOR);
    end
    n_cmp++;
    if ({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== {6{HEX_RST}}) begin
      n_err++;
      $display("FAIL reset_hex: got HEX0=%07b HEX5=%07b, want %07b", HEX0, HEX5, HEX_RST);
    end
    start = 1'b0;
    Resetn = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    n_cmp++;
    if ({busy, plot} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_release: got busy=%0b plot=%0b, want 0 0", busy, plot);
    end
  endtask

  task automatic test_fill;
    int np, nd, ng; bit to;
    exp_q.delete();
    push_rect(4, 12, 2, 6, 24'h123456);
    pulse_start(2'd1, 24'h123456);
    run_scoreboard(200, 0, np, nd, ng, to);
    n_cmp++;
    if (np !== 45 || nd !== 1 || ng !== 0 || to !== 1'b0 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL fill_frame: got plots=%0d dones=%0d gaps=%0d timeout=%0b left=%0d, want 45 1 0 0 0",
               np, nd, ng, to, exp_q.size());
    end
    n_cmp++;
    if ({busy, done, VGA_X, VGA_Y} !== {1'b0, 1'b0, NX'(4), NY'(2)}) begin
      n_err++;
      $display("FAIL fill_idle: got busy=%0b done=%0b x=%0d y=%0d, want 0 0 4 2", busy, done, VGA_X, VGA_Y);
    end
    @(negedge CLOCK_50);
    n_cmp++;
`ifdef VGA_FILL_HEX_EN
    if (HEX5 !== 7'b1111001 || HEX0 !== 7'b0000010) begin
      n_err++;
      $display("FAIL fill_hex: got HEX5=%07b HEX0=%07b, want 1111001 0000010", HEX5, HEX0);
    end
`else
    if ({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== {6{7'h7F}}) begin
      n_err++;
      $display("FAIL fill_hex: got HEX0=%07b HEX5=%07b, want 1111111", HEX0, HEX5);
    end
`endif
  endtask

  task automatic test_clear;
    int np, nd, ng; bit to;
    for (int m = 2; m <= 3; m++) begin
      exp_q.delete();
      push_rect(0, 15, 0, 7, 24'h000000);
      pulse_start(2'(m), 24'hABCDEF);
      run_scoreboard(300, 0, np, nd, ng, to);
      n_cmp++;
      if (np !== 128 || nd !== 1 || ng !== 0 || to !== 1'b0 || exp_q.size() !== 0) begin
        n_err++;
        $display("FAIL clear_mode%0d: got plots=%0d dones=%0d gaps=%0d timeout=%0b, want 128 1 0 0", m, np, nd, ng, to);
      end
    end
  endtask

  task automatic test_rainbow;
    int np, nd, ng; bit to;
    logic [23:0] c;
    logic [7:0] lv;
    exp_q.delete();
    // Closed-form frame colour: after the first frame each phase has 15 steps.
    for (int f = 0; f < 91; f++) begin
      if (f == 0) c = 24'hFF0000;
      else begin
        lv = 8'((((f - 1) % 15) + 1) * 17);
        case ((f - 1) / 15)
          0: c = {8'hFF, lv, 8'h00};
          1: c = {8'hFF - lv, 8'hFF, 8'h00};
          2: c = {8'h00, 8'hFF, lv};
          3: c = {8'h00, 8'hFF - lv, 8'hFF};
          4: c = {lv, 8'h00, 8'hFF};
          default: c = {8'hFF, 8'h00, 8'hFF - lv};
        endcase
      end
      push_rect(4, 12, 2, 6, c);
    end
    pulse_start(2'd0, 24'h00FF00);
    run_scoreboard(4300, 0, np, nd, ng, to);
    n_cmp++;
    if (np !== 4095 || nd !== 1 || ng !== 0 || to !== 1'b0 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL rainbow: got plots=%0d dones=%0d gaps=%0d timeout=%0b left=%0d, want 4095 1 0 0 0",
               np, nd, ng, to, exp_q.size());
    end
  endtask

  task automatic test_abort;
    int np, nd, ng, bad; bit to;
    exp_q.delete();
    push_rect(4, 12, 2, 6, 24'h0F0F0F);
    pulse_start(2'd1, 24'h0F0F0F);
    run_scoreboard(100, 20, np, nd, ng, to);
    abort = 1'b1;
    @(negedge CLOCK_50);
    abort = 1'b0;
    n_cmp++;
    if ({busy, done, plot, state_dbg} !== 5'b0 || exp_q.size() !== 25 || nd !== 0) begin
      n_err++;
      $display("FAIL abort_idle: got busy=%0b done=%0b plot=%0b state=%0d left=%0d, want 0 0 0 0 25",
               busy, done, plot, state_dbg, exp_q.size());
    end
    n_cmp++;
    if (VGA_X !== NX'(5) || VGA_Y !== NY'(4)) begin
      n_err++;
      $display("FAIL abort_hold: got x=%0d y=%0d, want 5 4", VGA_X, VGA_Y);
    end
    bad = 0;
    repeat (5) begin
      @(negedge CLOCK_50);
      if (done || plot || busy) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL abort_quiet: got %0d active cycles, want 0", bad);
    end
    exp_q.delete();
    push_rect(4, 12, 2, 6, 24'h00AA55);
    pulse_start(2'd1, 24'h00AA55);
    run_scoreboard(200, 0, np, nd, ng, to);
    n_cmp++;
    if (np !== 45 || nd !== 1 || ng !== 0 || to !== 1'b0 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL abort_restart: got plots=%0d dones=%0d gaps=%0d timeout=%0b, want 45 1 0 0", np, nd, ng, to);
    end
  endtask

  task automatic test_back_to_back;
    int np, nd, ng, tp, td, tg, bad; bit to, tt;
    exp_q.delete();
    push_rect(4, 12, 2, 6, 24'h00FF00);
    pulse_start(2'd1, 24'h00FF00);
    run_scoreboard(100, 10, np, nd, ng, to);
    tp = np; td = nd; tg = ng; tt = to;
    start = 1'b1; mode = 2'd2; fill_color = 24'hFFFFFF;
    run_scoreboard(100, 1, np, nd, ng, to);
    tp += np; td += nd; tg += ng; tt |= to;
    start = 1'b0;
    run_scoreboard(200, 0, np, nd, ng, to);
    tp += np; td += nd; tg += ng; tt |= to;
    n_cmp++;
    if (tp !== 45 || td !== 1 || tg !== 0 || tt !== 1'b0 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL restart_ignored: got plots=%0d dones=%0d gaps=%0d timeout=%0b, want 45 1 0 0", tp, td, tg, tt);
    end
    start = 1'b1; abort = 1'b1; mode = 2'd1;
    bad = 0;
    repeat (4) begin
      @(negedge CLOCK_50);
      if (busy || plot || done || state_dbg != 2'd0) bad++;
    end
    start = 1'b0; abort = 1'b0;
    @(negedge CLOCK_50);
    if (busy || plot) bad++;
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL start_abort_idle: got %0d active cycles, want 0", bad);
    end
  endtask

  task automatic test_reset_mid;
    int np, nd, ng, bad; bit to;
    exp_q.delete();
    push_rect(4, 12, 2, 6, 24'h5A5A5A);
    pulse_start(2'd1, 24'h5A5A5A);
    run_scoreboard(100, 30, np, nd, ng, to);
    Resetn = 1'b0;
    @(negedge CLOCK_50);
    n_cmp++;
    if ({busy, done, plot, state_dbg} !== 5'b0 || {VGA_X, VGA_Y, VGA_COLOR} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: got busy=%0b done=%0b plot=%0b state=%0d x=%0d y=%0d c=%06h, want all 0",
               busy, done, plot, state_dbg, VGA_X, VGA_Y, VGA_COLOR);
    end
    n_cmp++;
    if (HEX0 !== HEX_RST) begin
      n_err++;
      $display("FAIL reset_mid_hex: got HEX0=%07b, want %07b", HEX0, HEX_RST);
    end
    Resetn = 1'b1;
    exp_q.delete();
    bad = 0;
    repeat (4) begin
      @(negedge CLOCK_50);
      if (busy || plot || done) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL reset_mid_quiet: got %0d active cycles, want 0", bad);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_fill();
    test_clear();
    test_rainbow();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
